// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter with bounded burst lock in front of the data-memory port.
// Optional grant/conflict statistics counters are enabled by defining MEM_ARBITER_STATS_EN.
module mem_arbiter #(
    parameter int RD_LATENCY = 1,
    parameter int LOCK_MAX   = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic        i_m0_req,
    input  logic [29:0] i_m0_addr,
    input  logic [31:0] i_m0_data,
    input  logic        i_m0_wren,
    input  logic [3:0]  i_m0_mask,
    input  logic        i_m0_lock,
    output logic        o_m0_gnt,
    output logic        o_m0_rvalid,
    output logic [31:0] o_m0_rdata,

    input  logic        i_m1_req,
    input  logic [29:0] i_m1_addr,
    input  logic [31:0] i_m1_data,
    input  logic        i_m1_wren,
    input  logic [3:0]  i_m1_mask,
    input  logic        i_m1_lock,
    output logic        o_m1_gnt,
    output logic        o_m1_rvalid,
    output logic [31:0] o_m1_rdata,

    output logic [29:0] o_mem_addr,
    output logic [31:0] o_mem_data,
    output logic        o_mem_wren,
    output logic [3:0]  o_mem_mask,
    output logic        o_mem_valid,
`ifdef MEM_ARBITER_STATS_EN
    output logic [15:0] o_m0_gnt_cnt,
    output logic [15:0] o_m1_gnt_cnt,
    output logic [15:0] o_conflict_cnt,
`endif
    input  logic [31:0] i_mem_rdata
);

    localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);

    // Handshake: a master raises req with stable addr/data/wren/mask/lock and holds them
    // until gnt; the transfer happens on the rising edge where req & gnt are both high.

    logic       last_owner;   // 0 = M0, 1 = M1
    logic       last_lock;
    logic [7:0] lock_cnt;
    logic       lock_active;
    logic       both_req;
    logic       gnt0;
    logic       gnt1;
    logic       xfer;
    logic       sel_lock;
    logic       other_req;
    logic       rd_accept;

    logic [RD_LATENCY-1:0] tag_vld;
    logic [RD_LATENCY-1:0] tag_id;

    assign both_req    = i_m0_req & i_m1_req;
    assign lock_active = last_lock && (lock_cnt < LOCK_LIMIT);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (i_rst_n) begin
            if (both_req) begin
                // Lock keeps the previous owner; otherwise the other master takes its turn.
                if (lock_active) begin
                    gnt0 = ~last_owner;
                    gnt1 = last_owner;
                end else begin
                    gnt0 = last_owner;
                    gnt1 = ~last_owner;
                end
            end else begin
                gnt0 = i_m0_req;
                gnt1 = i_m1_req;
            end
        end
    end

    assign o_m0_gnt    = gnt0;
    assign o_m1_gnt    = gnt1;
    assign xfer        = gnt0 | gnt1;
    assign o_mem_valid = xfer;

    always_comb begin
        o_mem_addr = '0;
        o_mem_data = '0;
        o_mem_mask = '0;
        o_mem_wren = 1'b0;
        sel_lock   = 1'b0;
        other_req  = 1'b0;
        if (gnt0) begin
            o_mem_addr = i_m0_addr;
            o_mem_data = i_m0_data;
            o_mem_mask = i_m0_mask;
            o_mem_wren = i_m0_wren;
            sel_lock   = i_m0_lock;
            other_req  = i_m1_req;
        end else if (gnt1) begin
            o_mem_addr = i_m1_addr;
            o_mem_data = i_m1_data;
            o_mem_mask = i_m1_mask;
            o_mem_wren = i_m1_wren;
            sel_lock   = i_m1_lock;
            other_req  = i_m0_req;
        end
    end

    assign rd_accept = xfer & ~o_mem_wren;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_owner <= 1'b1;
            last_lock  <= 1'b0;
            lock_cnt   <= '0;
        end else if (xfer) begin
            last_owner <= gnt1;
            last_lock  <= sel_lock;
            // Count only locked back-to-back grants that actually make the other master wait.
            if ((gnt1 != last_owner) || !sel_lock) begin
                lock_cnt <= '0;
            end else if (other_req && (lock_cnt != LOCK_LIMIT)) begin
                lock_cnt <= lock_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld[0] <= rd_accept;
            tag_id[0]  <= gnt1;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end

    assign o_m0_rvalid = tag_vld[RD_LATENCY-1] & ~tag_id[RD_LATENCY-1];
    assign o_m1_rvalid = tag_vld[RD_LATENCY-1] &  tag_id[RD_LATENCY-1];
    assign o_m0_rdata  = i_mem_rdata;
    assign o_m1_rdata  = i_mem_rdata;

`ifdef MEM_ARBITER_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_m0_gnt_cnt   <= '0;
            o_m1_gnt_cnt   <= '0;
            o_conflict_cnt <= '0;
        end else begin
            if (gnt0 && (o_m0_gnt_cnt != 16'hFFFF)) o_m0_gnt_cnt <= o_m0_gnt_cnt + 16'd1;
            if (gnt1 && (o_m1_gnt_cnt != 16'hFFFF)) o_m1_gnt_cnt <= o_m1_gnt_cnt + 16'd1;
            if (both_req && (o_conflict_cnt != 16'hFFFF)) o_conflict_cnt <= o_conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master arbiter placed in front of the data-memory/MMIO crossbar.
- Shares the single word-addressed memory port between M0 (CPU load/store unit) and M1 (loader/debug DMA).
- Round-robin arbitration with bounded burst lock.
- Routes read data back to the issuing master using a latency-matched tag pipeline.

Parameters:
RD_LATENCY, 1, cycles from read accept to valid i_mem_rdata; legal range 1..4
LOCK_MAX, 8, max consecutive locked grants to one master while the other waits; legal range 1..255

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_m0_req  input  1  M0 request valid
i_m0_addr  input  30  M0 word address
i_m0_data  input  32  M0 write data
i_m0_wren  input  1  M0 write enable
i_m0_mask  input  4  M0 byte mask
i_m0_lock  input  1  M0 requests to keep grant for next transfer
o_m0_gnt  output  1  M0 transfer accepted this cycle
o_m0_rvalid  output  1  M0 read data valid
o_m0_rdata  output  32  M0 read data
i_m1_*/o_m1_*  same set as M0, for M1
o_mem_addr  output  30  to crossbar i_addr
o_mem_data  output  32  to crossbar i_data
o_mem_wren  output  1  to crossbar i_wren
o_mem_mask  output  4  to crossbar i_mask
o_mem_valid  output  1  a transfer is issued this cycle
i_mem_rdata  input  32  from crossbar o_data

Behaviour:
- Reset (async assert, sync deassert by the consumer): last_owner=M1 (so M0 wins the first tie); lock_cnt=0; tag pipeline cleared; all rvalid=0; gnt combinationally 0 while reset is asserted.
- Grant is combinational from registered state and current requests. A transfer occurs on a rising edge with req&gnt. At most one gnt is high per cycle. A master holds req/addr/data/wren/mask stable until granted.
- Arbitration, per cycle:
  - No requests: no grant.
  - Exactly one requester: it is granted.
  - Both requesting: lock_active (previous transfer's owner had lock=1 and lock_cnt<LOCK_MAX) keeps the owner; otherwise the master that is not last_owner is granted.
- lock_cnt:
  - Increments on a granted locked transfer by the same owner while the other master requests.
  - Resets to 0 on owner change or on a transfer with lock=0.
  - Saturates at LOCK_MAX. At saturation with both requesting, the other master is forced in.
- Mux: o_mem_addr/data/mask come from the granted master. With no grant, they are all zero.
- o_mem_wren = gnt & wren of the granted master. It is never high without a grant.
- o_mem_valid = any gnt.
- Read accept (gnt & !wren) pushes tag {valid=1, id} into a RD_LATENCY-deep shift register. Writes push valid=0.
- o_mN_rvalid is high exactly RD_LATENCY cycles after the accept edge, when the tag output has valid=1 and id=N.
- o_m0_rdata = o_m1_rdata = i_mem_rdata (broadcast). Only rvalid qualifies it.
- Back-to-back reads are supported at one per cycle with no bubbles. Responses return in issue order.
- Writes complete at the accept edge and produce no response.
- Reset mid-operation: in-flight tags are discarded and no rvalid follows; lock state and last_owner return to reset values.
- Requests are never dropped. A waiting master is granted within LOCK_MAX+1 cycles.

Optional Feature:
- Macro: MEM_ARBITER_STATS_EN.
- Defined: adds outputs o_m0_gnt_cnt[15:0], o_m1_gnt_cnt[15:0] and o_conflict_cnt[15:0].
  - Grant counters count transfers per master.
  - o_conflict_cnt counts cycles with both req high.
  - All counters are saturating at 16'hFFFF and reset to 0.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Single master: M0 reads addr 30'h10 with no M1 traffic, RD_LATENCY=1 -> o_m0_gnt same cycle; o_m0_rvalid one cycle later with rdata=memory word; o_m1_rvalid stays 0.
- Tie from reset: both req, no lock -> M0, M1, M0, M1 alternate; o_mem_addr follows the granted master each cycle.
- Lock bound: LOCK_MAX=4, M1 req+lock continuously, M0 req continuously -> M1 granted 5 consecutive cycles (first grant plus 4 locked), then M0 granted; M1 never starves M0 beyond that.
- Latency/order: RD_LATENCY=3; reads M0@A, M1@B, write M0, read M1@C on consecutive cycles -> rvalid pattern M0, M1, none, M1 on cycles 3..6 after the first accept, matching data.
- Reset mid-flight: RD_LATENCY=2; read accepted, i_rst_n low 1 cycle later -> no rvalid ever appears; after release, M0 wins the next tie.
- Stats (MEM_ARBITER_STATS_EN): 10 cycles both req -> o_conflict_cnt=10, o_m0_gnt_cnt=5, o_m1_gnt_cnt=5; 70000 M0 grants -> o_m0_gnt_cnt=16'hFFFF.
